// File: rtl/window_3x3_gen.sv
// window_3x3_gen: turns a raster pixel stream into 3x3 windows using two line buffers.
// One registered output stage; upstream stalls whenever that stage is full and not draining.
module window_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_sof,
  input  logic                    in_eof,
  input  logic                    in_sol,
  input  logic                    in_eol,
  output logic                    win_val,
  input  logic                    win_rdy,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic                    win_sof,
  output logic                    win_eof,
  output logic                    win_sol,
  output logic                    win_eol
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(MAX_WIDTH - 1);
  localparam int DW = DATA_WIDTH;
  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_row, w_row_nxt;
  logic [ADDR_WIDTH-1:0]   r_col, w_col_nxt;
  logic [DW-1:0]           r_lb0 [MAX_WIDTH];
  logic [DW-1:0]           r_lb1 [MAX_WIDTH];
  logic [9*DW-1:0]         r_sh, w_win;
  logic                    w_go, w_emit;
  assign in_rdy = rst_n && (!win_val || win_rdy);
  assign w_go   = in_val && in_rdy && (r_state == ACTIVE || in_sof);
  // row only needs to distinguish 0,1,2 and "2 or more", so it saturates at 3
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    if (w_go) begin
      w_state_nxt = in_eof ? IDLE : ACTIVE;
      w_row_nxt   = in_sof ? 2'd0 : in_sol ? (r_row == 2'd3 ? r_row : r_row + 2'd1) : r_row;
      w_col_nxt   = (in_sof || in_sol) ? '0 : (r_col == COL_MAX ? r_col : r_col + 1'b1);
    end
    w_win  = {r_sh[8*DW-1:6*DW], r_lb0[w_col_nxt], r_sh[5*DW-1:3*DW], r_lb1[w_col_nxt],
              r_sh[2*DW-1:0], in_data};
    w_emit = w_go && w_row_nxt >= 2'd2 && w_col_nxt >= ADDR_WIDTH'(2);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_sh     <= '0;
      win_val  <= 1'b0;
      win_data <= '0;
      win_sof  <= 1'b0;
      win_eof  <= 1'b0;
      win_sol  <= 1'b0;
      win_eol  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      if (w_go) r_sh <= w_win;
      if (w_emit) begin
        win_val  <= 1'b1;
        win_data <= w_win;
        win_sof  <= w_row_nxt == 2'd2 && w_col_nxt == ADDR_WIDTH'(2);
        win_eof  <= in_eof;
        win_sol  <= w_col_nxt == ADDR_WIDTH'(2);
        win_eol  <= in_eol;
      end else if (win_rdy) begin
        win_val <= 1'b0;
      end
    end
  end
  // LB1 holds the previous line, LB0 the one before; both shift down a line per write
  always_ff @(posedge clk) begin
    if (w_go) begin
      r_lb0[w_col_nxt] <= r_lb1[w_col_nxt];
      r_lb1[w_col_nxt] <= in_data;
    end
  end
endmodule
